// File: rtl/spi_block_writer_if.sv
// spi_block_writer_if: SPI pins plus the block-memory write port and fill status.
interface spi_block_writer_if #(parameter int ADDR_W = 11);
  logic              ss;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [5:0]        wr_data;
  logic              busy;
  modport slave  (input ss, sclk, mosi, output miso, wr_en, wr_addr, wr_data, busy);
  modport master (output ss, sclk, mosi, input miso, wr_en, wr_addr, wr_data, busy);
endinterface

// File: rtl/spi_block_writer.sv
// spi_block_writer: SPI mode-0 command receiver driving pixel-block writes, hardware fill and status readback.
module spi_block_writer #(
  parameter int NUM_BLOCKS = 1200,
  parameter int ADDR_W     = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_block_writer_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, DATA, FILL_COLOR, FILL, IGNORE} state_t;
  state_t            state, state_d;
  logic [1:0]        ss_s, mosi_s;
  logic [2:0]        sclk_s, cnt;
  logic [6:0]        sh;
  logic [7:0]        byte_q, miso_sh;
  logic              byte_done, ss_sync, rise, fall;
  logic [ADDR_W-1:0] ptr, ptr_d, ptr_inc, full;
  logic [5:0]        color, color_d, wd;
  logic              we, err, ovr, err_set, ovr_set, stat_ld;
  assign ss_sync  = ss_s[1];
  assign rise     = sclk_s[1] & ~sclk_s[2];
  assign fall     = ~sclk_s[1] & sclk_s[2];
  assign ptr_inc  = ptr == ADDR_W'(NUM_BLOCKS - 1) ? '0 : ptr + 1'b1;
  assign full     = {ptr[ADDR_W-1:8], byte_q};
  assign bus.miso = miso_sh[7] & ~ss_sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ss_s      <= 2'b11;
      mosi_s    <= '0;
      sclk_s    <= '0;
      cnt       <= '0;
      sh        <= '0;
      byte_q    <= '0;
      byte_done <= 1'b0;
    end else begin
      ss_s      <= {ss_s[0], bus.ss};
      mosi_s    <= {mosi_s[0], bus.mosi};
      sclk_s    <= {sclk_s[1:0], bus.sclk};
      byte_done <= rise && !ss_sync && cnt == 3'd7;
      if (ss_sync) cnt <= '0;
      else if (rise) begin
        cnt <= cnt + 1'b1;
        sh  <= {sh[5:0], mosi_s[1]};
        if (cnt == 3'd7) byte_q <= {sh, mosi_s[1]};
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    color_d = color;
    we      = 1'b0;
    wd      = byte_q[5:0];
    err_set = 1'b0;
    ovr_set = 1'b0;
    stat_ld = 1'b0;
    if (state == FILL) begin
      we      = 1'b1;
      wd      = color;
      ptr_d   = ptr_inc;
      ovr_set = byte_done;
      state_d = ptr == ADDR_W'(NUM_BLOCKS - 1) ? IDLE : FILL;
    end else if (ss_sync) state_d = IDLE;
    else if (byte_done)
      case (state)
        IDLE: begin
          stat_ld = byte_q == 8'h03;
          state_d = byte_q == 8'h01 ? ADDR_HI : byte_q == 8'h02 ? FILL_COLOR : IGNORE;
        end
        ADDR_HI: begin
          ptr_d   = {byte_q[ADDR_W-9:0], ptr[7:0]};
          state_d = ADDR_LO;
        end
        ADDR_LO: begin
          err_set = full >= ADDR_W'(NUM_BLOCKS);
          ptr_d   = err_set ? '0 : full;
          state_d = DATA;
        end
        DATA: begin
          we    = 1'b1;
          ptr_d = ptr_inc;
        end
        FILL_COLOR: begin
          color_d = byte_q[5:0];
          ptr_d   = '0;
          state_d = FILL;
        end
        default: state_d = state;
      endcase
  end
  // A status byte shifts only on falls inside a byte, so the MSB survives the command's trailing fall.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr         <= '0;
      color       <= '0;
      err         <= 1'b0;
      ovr         <= 1'b0;
      miso_sh     <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.busy    <= 1'b0;
    end else begin
      ptr       <= ptr_d;
      color     <= color_d;
      err       <= err_set | (err & ~stat_ld);
      ovr       <= ovr_set | (ovr & ~stat_ld);
      bus.busy  <= state == FILL;
      bus.wr_en <= we;
      if (we) begin
        bus.wr_addr <= ptr;
        bus.wr_data <= wd;
      end
      miso_sh <= ss_sync ? '0 : stat_ld ? {bus.busy, err, ovr, 5'b0} :
                 (fall && cnt != 3'd0) ? {miso_sh[6:0], 1'b0} : miso_sh;
    end
endmodule

// File: tb/tb_spi_block_writer.sv
// tb_spi_block_writer: directed SPI transactions against hand-computed block writes and status bytes.
module tb_spi_block_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  spi_block_writer_if #(.ADDR_W(11)) bus();
  spi_block_writer #(.NUM_BLOCKS(1200), .ADDR_W(11)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, errors = 0, cyc = 0, busy_n = 0, busy_last = 0, bad = 0;
  int wa[$], wd[$], wc[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx, v;
  logic found;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst_n) begin
      if (bus.wr_en) begin
        wa.push_back(int'(bus.wr_addr));
        wd.push_back(int'(bus.wr_data));
        wc.push_back(cyc);
      end
      if (bus.busy) begin
        busy_n++;
        busy_last = cyc;
      end
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
    r = '0;
    for (int i = 7; i > 7 - n; i--) begin
      bus.mosi = tx[i];
      clks(5);
      r[i] = bus.miso;
      bus.sclk = 1'b1;
      clks(5);
      bus.sclk = 1'b0;
    end
  endtask
  task automatic spi_start;
    bus.ss = 1'b0;
    clks(5);
  endtask
  task automatic spi_end;
    clks(5);
    bus.ss = 1'b1;
    clks(10);
  endtask
  task automatic xfer;
    spi_start();
    foreach (tx_q[i]) spi_bits(tx_q[i], 8, rx);
    spi_end();
  endtask
  task automatic status_read(output logic [7:0] s);
    spi_start();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h00, 8, s);
    spi_end();
  endtask
  task automatic clear_log;
    wa.delete();
    wd.delete();
    wc.delete();
    busy_n = 0;
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"}, bus.wr_en, 0);
    check({tag, "_wr_addr"}, bus.wr_addr, 0);
    check({tag, "_wr_data"}, bus.wr_data, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_miso"}, bus.miso, 0);
  endtask
  initial begin
    bus.ss = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    clks(3);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    clks(5);
    clear_log();
    tx_q = '{8'h01, 8'h00, 8'h05, 8'h30, 8'h0C, 8'h03};
    xfer();
    check("w3_count", wa.size(), 3);
    check("w3_a0", wa[0], 5);
    check("w3_d0", wd[0], 'h30);
    check("w3_a1", wa[1], 6);
    check("w3_d1", wd[1], 'h0C);
    check("w3_a2", wa[2], 7);
    check("w3_d2", wd[2], 'h03);
    clear_log();
    tx_q = '{8'h01, 8'h04, 8'hAF, 8'h3F, 8'h01};
    xfer();
    check("wrap_count", wa.size(), 2);
    check("wrap_a0", wa[0], 1199);
    check("wrap_d0", wd[0], 'h3F);
    check("wrap_a1", wa[1], 0);
    check("wrap_d1", wd[1], 'h01);
    clear_log();
    tx_q = '{8'h01, 8'h07, 8'hFF, 8'h11};
    xfer();
    check("bad_count", wa.size(), 1);
    check("bad_a0", wa[0], 0);
    check("bad_d0", wd[0], 'h11);
    status_read(v);
    check("stat_err", v, 'h40);
    status_read(v);
    check("stat_clr", v, 'h00);
    clear_log();
    tx_q = '{8'h02, 8'h15};
    xfer();
    tx_q = '{8'h55};
    xfer();
    for (int i = 0; i < 3000 && bus.busy; i++) clks(1);
    check("fill_done", bus.busy, 0);
    clks(5);
    check("fill_count", wa.size(), 1200);
    bad = 0;
    foreach (wa[i]) if (wa[i] != i || wd[i] != 'h15 || wc[i] != wc[0] + i) bad++;
    check("fill_seq_bad", bad, 0);
    check("fill_busy_cycles", busy_n, 1200);
    check("fill_busy_fall", busy_last, wc.size() > 0 ? wc[wc.size() - 1] : -1);
    status_read(v);
    check("stat_ovr", v, 'h20);
    clear_log();
    tx_q = '{8'h02, 8'h2A};
    xfer();
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      found = bus.wr_en && bus.wr_addr == 11'd500;
    end
    check("rfill_at500", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("rfill");
    clks(2);
    rst_n = 1'b1;
    clks(5);
    status_read(v);
    check("rfill_stat", v, 'h00);
    clear_log();
    spi_start();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h09, 8, rx);
    spi_bits(8'hFF, 5, rx);
    spi_end();
    clks(5);
    check("part_none", wa.size(), 0);
    clear_log();
    tx_q = '{8'h01, 8'h00, 8'h02, 8'h0A};
    xfer();
    check("part_count", wa.size(), 1);
    check("part_a0", wa[0], 2);
    check("part_d0", wd[0], 'h0A);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
